vga_pixel_unpacker: RTL and testbench

//  Parametrised successor to the single-word 2-bit pixel selector. Fetches packed scanline

---
 rtl/vga_pixel_unpacker_if.sv | 28 ++
 rtl/vga_pixel_unpacker.sv | 152 +++++++++++++++
 tb/tb_vga_pixel_unpacker.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_unpacker_if.sv
// Frame-buffer fetch handshake and pixel output bundle of the scanline pixel unpacker.
// The unpacker takes the slave view; the frame-buffer side and the pixel consumer take the master view.
interface vga_pixel_unpacker_if #(
    parameter int WORD_W = 64,
    parameter int BPP    = 2
);
    logic              word_req;
    logic              word_ack;
    logic [WORD_W-1:0] word_data;
    logic [BPP-1:0]    pixel;
    logic              pixel_valid;

    modport master (
        input  word_req,
        output word_ack,
        output word_data,
        input  pixel,
        input  pixel_valid
    );

    modport slave (
        output word_req,
        input  word_ack,
        input  word_data,
        output pixel,
        output pixel_valid
    );
endinterface

// File: rtl/vga_pixel_unpacker.sv
// Scanline pixel unpacker: fetches packed words over req/ack, double-buffers them
// (shift register + one prefetch word) and emits one BPP-bit pixel per enable, MSB-first.
module vga_pixel_unpacker #(
    parameter int WORD_W   = 64,
    parameter int BPP      = 2,
    parameter int LINE_PIX = 640
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 line_start,
    vga_pixel_unpacker_if.slave  bus,
    output logic                 underrun
);
    localparam int PPW    = WORD_W / BPP;
    localparam int NWORDS = (LINE_PIX + PPW - 1) / PPW;
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PIX_W  = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
    localparam int WREQ_W = $clog2(NWORDS + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PPW - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIX - 1);
    localparam logic [WREQ_W-1:0] WREQ_MAX  = WREQ_W'(NWORDS);

    typedef enum logic [1:0] {IDLE, FILL, RUN, ERR} state_t;

    state_t             state_reg;
    logic [WORD_W-1:0]  shift_reg;
    logic [WORD_W-1:0]  pref_reg;
    logic               pref_valid_reg;
    logic [SLOT_W-1:0]  slot_reg;
    logic [PIX_W-1:0]   pix_reg;
    logic [WREQ_W-1:0]  wreq_reg;
    logic               word_req_reg;
    logic [BPP-1:0]     pixel_reg;
    logic               pixel_valid_reg;
    logic               underrun_reg;

    logic ack_fire;
    logic wreq_room;

    assign ack_fire  = word_req_reg & bus.word_ack;
    assign wreq_room = (wreq_reg != WREQ_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            pref_reg        <= '0;
            pref_valid_reg  <= 1'b0;
            slot_reg        <= '0;
            pix_reg         <= '0;
            wreq_reg        <= '0;
            word_req_reg    <= 1'b0;
            pixel_reg       <= '0;
            pixel_valid_reg <= 1'b0;
            underrun_reg    <= 1'b0;
        end else if (line_start) begin
            // Restart wins over everything; an ack landing in this cycle is dropped.
            state_reg       <= FILL;
            shift_reg       <= '0;
            pref_reg        <= '0;
            pref_valid_reg  <= 1'b0;
            slot_reg        <= '0;
            pix_reg         <= '0;
            wreq_reg        <= '0;
            word_req_reg    <= 1'b0;
            pixel_valid_reg <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            pixel_valid_reg <= 1'b0;

            // Request generator: one low cycle after every ack, never past NWORDS.
            if (ack_fire) begin
                word_req_reg <= 1'b0;
                wreq_reg     <= wreq_reg + WREQ_W'(1);
            end else if (!word_req_reg && wreq_room &&
                         ((state_reg == FILL) || (state_reg == RUN && !pref_valid_reg))) begin
                word_req_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                end

                FILL: begin
                    if (ack_fire) begin
                        shift_reg <= bus.word_data;
                        slot_reg  <= '0;
                        pix_reg   <= '0;
                        state_reg <= RUN;
                    end
                end

                RUN: begin
                    if (ack_fire && !pref_valid_reg) begin
                        pref_reg       <= bus.word_data;
                        pref_valid_reg <= 1'b1;
                    end
                    if (enable) begin
                        pixel_reg       <= shift_reg[WORD_W-1 -: BPP];
                        pixel_valid_reg <= 1'b1;
                        shift_reg       <= shift_reg << BPP;
                        slot_reg        <= slot_reg + SLOT_W'(1);
                        pix_reg         <= pix_reg + PIX_W'(1);
                        if (pix_reg == PIX_LAST) begin
                            state_reg      <= IDLE;
                            pref_valid_reg <= 1'b0;
                            word_req_reg   <= 1'b0;
                            slot_reg       <= '0;
                            pix_reg        <= '0;
                        end else if (slot_reg == SLOT_LAST) begin
                            slot_reg <= '0;
                            if (pref_valid_reg) begin
                                shift_reg      <= pref_reg;
                                pref_valid_reg <= 1'b0;
                            end else if (ack_fire) begin
                                // Word arrived exactly on the wrap: bypass the prefetch slot.
                                shift_reg      <= bus.word_data;
                                pref_valid_reg <= 1'b0;
                            end else begin
                                state_reg    <= ERR;
                                underrun_reg <= 1'b1;
                                word_req_reg <= 1'b0;
                            end
                        end
                    end
                end

                ERR: begin
                    word_req_reg <= 1'b0;
                    if (enable) begin
                        pixel_reg       <= '0;
                        pixel_valid_reg <= 1'b1;
                        pix_reg         <= pix_reg + PIX_W'(1);
                        if (pix_reg == PIX_LAST) begin
                            state_reg <= IDLE;
                            pix_reg   <= '0;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.word_req    = word_req_reg;
    assign bus.pixel       = pixel_reg;
    assign bus.pixel_valid = pixel_valid_reg;
    assign underrun        = underrun_reg;
endmodule

// File: tb/tb_vga_pixel_unpacker.sv
// Directed bench for vga_pixel_unpacker: a 2-bpp/64-pixel instance and an 8-bpp/16-pixel instance.
module tb_vga_pixel_unpacker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en_a, ls_a, ur_a;
    logic en_b, ls_b, ur_b;

    vga_pixel_unpacker_if #(.WORD_W(64), .BPP(2)) bus_a ();
    vga_pixel_unpacker_if #(.WORD_W(64), .BPP(8)) bus_b ();

    vga_pixel_unpacker #(.WORD_W(64), .BPP(2), .LINE_PIX(64)) dut_a (
        .clock(clk), .reset(rst_n), .enable(en_a), .line_start(ls_a),
        .bus(bus_a), .underrun(ur_a)
    );

    vga_pixel_unpacker #(.WORD_W(64), .BPP(8), .LINE_PIX(16)) dut_b (
        .clock(clk), .reset(rst_n), .enable(en_b), .line_start(ls_b),
        .bus(bus_b), .underrun(ur_b)
    );

    localparam logic [63:0] W_E4  = {8{8'hE4}};
    localparam logic [63:0] W_1B  = {8{8'h1B}};
    localparam logic [63:0] W_ONE = {8{8'hFF}};

    int tests = 0;
    int fails = 0;
    logic [7:0] got [0:127];
    int n_got;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_a();
        @(negedge clk);
        if (bus_a.pixel_valid === 1'b1 && n_got < 128) begin
            got[n_got] = 8'(bus_a.pixel);
            n_got++;
        end
    endtask

    task automatic pulse_ls_a();
        @(negedge clk);
        ls_a = 1'b1;
        @(negedge clk);
        ls_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; ls_a = 1'b0; ls_b = 1'b0;
        bus_a.word_ack = 1'b0; bus_a.word_data = '0;
        bus_b.word_ack = 1'b0; bus_b.word_data = '0;
        repeat (3) @(negedge clk);
        tests++; if (bus_a.word_req !== 1'b0) begin fails++; $display("FAIL reset_req_a: got %b want 0", bus_a.word_req); end
        tests++; if (bus_a.pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_valid_a: got %b want 0", bus_a.pixel_valid); end
        tests++; if (bus_a.pixel !== 2'd0) begin fails++; $display("FAIL reset_pixel_a: got %0d want 0", bus_a.pixel); end
        tests++; if (ur_a !== 1'b0) begin fails++; $display("FAIL reset_underrun_a: got %b want 0", ur_a); end
        tests++; if (bus_b.word_req !== 1'b0 || bus_b.pixel_valid !== 1'b0 || ur_b !== 1'b0) begin
            fails++; $display("FAIL reset_b: req %b valid %b underrun %b want all 0", bus_b.word_req, bus_b.pixel_valid, ur_b);
        end
        rst_n = 1'b1; en_a = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus_a.word_req !== 1'b0 || bus_a.pixel_valid !== 1'b0) begin
            fails++; $display("FAIL idle_a: req %b valid %b want 0 0", bus_a.word_req, bus_a.pixel_valid);
        end
    endtask

    task automatic test_basic_line();
        int acks; int errs; int bad_i; int bad_v; int bad_e;
        acks = 0; errs = 0; bad_i = 0; bad_v = 0; bad_e = 0; n_got = 0;
        en_a = 1'b1;
        pulse_ls_a();
        for (int c = 0; c < 300 && n_got < 64; c++) begin
            tick_a();
            bus_a.word_data = W_E4;
            bus_a.word_ack = bus_a.word_req;
            if (bus_a.word_req === 1'b1) acks++;
        end
        bus_a.word_ack = 1'b0;
        repeat (4) tick_a();
        for (int i = 0; i < 64; i++) begin
            if (got[i] !== 8'(3 - (i % 4))) begin
                if (errs == 0) begin bad_i = i; bad_v = int'(got[i]); bad_e = 3 - (i % 4); end
                errs++;
            end
        end
        tests++; if (n_got != 64) begin fails++; $display("FAIL basic_count: got %0d pixels want 64", n_got); end
        tests++; if (errs != 0) begin fails++; $display("FAIL basic_pixels: pixel %0d got %0d want %0d (%0d wrong)", bad_i, bad_v, bad_e, errs); end
        tests++; if (acks != 2) begin fails++; $display("FAIL basic_acks: got %0d want 2", acks); end
        tests++; if (ur_a !== 1'b0) begin fails++; $display("FAIL basic_underrun: got %b want 0", ur_a); end
        tests++; if (bus_a.word_req !== 1'b0 || bus_a.pixel_valid !== 1'b0) begin
            fails++; $display("FAIL basic_idle: req %b valid %b want 0 0", bus_a.word_req, bus_a.pixel_valid);
        end
    endtask

    task automatic test_bpp8_sparse_enable();
        int acks; int errs; int bad_en; int n; int bad_i; int bad_v;
        acks = 0; errs = 0; bad_en = 0; n = 0; bad_i = 0; bad_v = 0;
        @(negedge clk); ls_b = 1'b1;
        @(negedge clk); ls_b = 1'b0;
        for (int c = 0; c < 400 && n < 16; c++) begin
            @(negedge clk);
            if (bus_b.pixel_valid === 1'b1) begin
                if (en_b !== 1'b1) bad_en++;
                if (n < 128) got[n] = bus_b.pixel;
                n++;
            end
            en_b = ((c % 4) == 0);
            bus_b.word_data = (acks == 0) ? 64'h0001020304050607 : 64'h08090A0B0C0D0E0F;
            bus_b.word_ack = bus_b.word_req;
            if (bus_b.word_req === 1'b1) acks++;
        end
        en_b = 1'b0; bus_b.word_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus_b.pixel_valid === 1'b1) n++;
        end
        for (int i = 0; i < 16; i++) begin
            if (got[i] !== 8'(i)) begin
                if (errs == 0) begin bad_i = i; bad_v = int'(got[i]); end
                errs++;
            end
        end
        tests++; if (n != 16) begin fails++; $display("FAIL bpp8_count: got %0d pixels want 16", n); end
        tests++; if (errs != 0) begin fails++; $display("FAIL bpp8_pixels: pixel %0d got %0d want %0d", bad_i, bad_v, bad_i); end
        tests++; if (bad_en != 0) begin fails++; $display("FAIL bpp8_valid_timing: %0d valid cycles without prior enable, want 0", bad_en); end
        tests++; if (acks != 2 || ur_b !== 1'b0) begin fails++; $display("FAIL bpp8_acks: acks %0d underrun %b want 2 0", acks, ur_b); end
    endtask

    task automatic test_underrun();
        int acks; int errs; int req_in_err; int bad_i; int bad_v; int bad_e; int e;
        acks = 0; errs = 0; req_in_err = 0; bad_i = 0; bad_v = 0; bad_e = 0; n_got = 0;
        en_a = 1'b1;
        pulse_ls_a();
        for (int c = 0; c < 300 && n_got < 64; c++) begin
            tick_a();
            if (n_got >= 33 && bus_a.word_req !== 1'b0) req_in_err++;
            if (bus_a.word_req === 1'b1 && acks == 0) begin
                bus_a.word_ack = 1'b1; bus_a.word_data = W_E4; acks++;
            end else if (n_got >= 40 && n_got < 44) begin
                bus_a.word_ack = 1'b1; bus_a.word_data = W_ONE;
            end else begin
                bus_a.word_ack = 1'b0;
            end
        end
        bus_a.word_ack = 1'b0;
        repeat (3) tick_a();
        for (int i = 0; i < 64; i++) begin
            e = (i < 32) ? 3 - (i % 4) : 0;
            if (got[i] !== 8'(e)) begin
                if (errs == 0) begin bad_i = i; bad_v = int'(got[i]); bad_e = e; end
                errs++;
            end
        end
        tests++; if (n_got != 64) begin fails++; $display("FAIL underrun_count: got %0d pixels want 64", n_got); end
        tests++; if (errs != 0) begin fails++; $display("FAIL underrun_pixels: pixel %0d got %0d want %0d (%0d wrong)", bad_i, bad_v, bad_e, errs); end
        tests++; if (req_in_err != 0) begin fails++; $display("FAIL underrun_req_low: word_req high in %0d error cycles, want 0", req_in_err); end
        tests++; if (ur_a !== 1'b1) begin fails++; $display("FAIL underrun_flag: got %b want 1", ur_a); end
        @(negedge clk); ls_a = 1'b1;
        @(negedge clk); ls_a = 1'b0;
        tests++; if (ur_a !== 1'b0) begin fails++; $display("FAIL underrun_clear: got %b want 0 after line_start", ur_a); end
    endtask

    task automatic test_wrap_ack();
        int acks; int errs; int bad_i; int bad_v; int bad_e; int e;
        acks = 0; errs = 0; bad_i = 0; bad_v = 0; bad_e = 0; n_got = 0;
        en_a = 1'b1;
        pulse_ls_a();
        for (int c = 0; c < 300 && n_got < 64; c++) begin
            tick_a();
            if (bus_a.word_req === 1'b1 && acks == 0) begin
                bus_a.word_ack = 1'b1; bus_a.word_data = W_E4; acks++;
            end else if (bus_a.word_req === 1'b1 && n_got == 31) begin
                bus_a.word_ack = 1'b1; bus_a.word_data = W_1B; acks++;
            end else begin
                bus_a.word_ack = 1'b0;
            end
        end
        bus_a.word_ack = 1'b0;
        repeat (3) tick_a();
        for (int i = 0; i < 64; i++) begin
            e = (i < 32) ? 3 - (i % 4) : (i % 4);
            if (got[i] !== 8'(e)) begin
                if (errs == 0) begin bad_i = i; bad_v = int'(got[i]); bad_e = e; end
                errs++;
            end
        end
        tests++; if (acks != 2) begin fails++; $display("FAIL wrap_acks: got %0d want 2", acks); end
        tests++; if (got[32] !== 8'd0) begin fails++; $display("FAIL wrap_pixel32: got %0d want 0", got[32]); end
        tests++; if (errs != 0 || n_got != 64) begin fails++; $display("FAIL wrap_pixels: pixel %0d got %0d want %0d (%0d wrong, %0d seen)", bad_i, bad_v, bad_e, errs, n_got); end
        tests++; if (ur_a !== 1'b0) begin fails++; $display("FAIL wrap_underrun: got %b want 0", ur_a); end
    endtask

    task automatic test_restart_and_reset();
        int acks; int errs; int bad_i; int bad_v; int bad_e; int e;
        acks = 0; errs = 0; bad_i = 0; bad_v = 0; bad_e = 0; n_got = 0;
        en_a = 1'b1;
        pulse_ls_a();
        for (int c = 0; c < 100 && n_got < 20; c++) begin
            tick_a();
            bus_a.word_data = W_E4;
            bus_a.word_ack = (bus_a.word_req === 1'b1 && acks == 0);
            if (bus_a.word_ack) acks++;
        end
        tests++; if (bus_a.word_req !== 1'b1 || n_got != 20) begin
            fails++; $display("FAIL restart_pre: word_req %b at pixel %0d want 1 at 20", bus_a.word_req, n_got);
        end
        ls_a = 1'b1; bus_a.word_ack = 1'b1; bus_a.word_data = W_ONE;
        @(negedge clk);
        ls_a = 1'b0; bus_a.word_ack = 1'b0;
        tests++; if (bus_a.word_req !== 1'b0 || bus_a.pixel_valid !== 1'b0) begin
            fails++; $display("FAIL restart_req_low: req %b valid %b want 0 0", bus_a.word_req, bus_a.pixel_valid);
        end
        n_got = 0; acks = 0;
        for (int c = 0; c < 300 && n_got < 64; c++) begin
            tick_a();
            bus_a.word_data = (acks == 0) ? W_1B : W_E4;
            bus_a.word_ack = bus_a.word_req;
            if (bus_a.word_req === 1'b1) acks++;
        end
        bus_a.word_ack = 1'b0;
        for (int i = 0; i < 64; i++) begin
            e = (i < 32) ? (i % 4) : 3 - (i % 4);
            if (got[i] !== 8'(e)) begin
                if (errs == 0) begin bad_i = i; bad_v = int'(got[i]); bad_e = e; end
                errs++;
            end
        end
        tests++; if (errs != 0 || n_got != 64) begin fails++; $display("FAIL restart_pixels: pixel %0d got %0d want %0d (%0d wrong, %0d seen)", bad_i, bad_v, bad_e, errs, n_got); end
        repeat (2) tick_a();
        // Mid-line asynchronous reset with all-ones data so the pixel is visibly nonzero beforehand.
        n_got = 0; acks = 0;
        pulse_ls_a();
        for (int c = 0; c < 100 && n_got < 10; c++) begin
            tick_a();
            bus_a.word_data = W_ONE;
            bus_a.word_ack = bus_a.word_req;
        end
        tests++; if (bus_a.pixel_valid !== 1'b1 || bus_a.pixel !== 2'd3) begin
            fails++; $display("FAIL reset_pre: valid %b pixel %0d want 1 3", bus_a.pixel_valid, bus_a.pixel);
        end
        rst_n = 1'b0;
        #1;
        tests++; if (bus_a.pixel !== 2'd0 || bus_a.pixel_valid !== 1'b0 || bus_a.word_req !== 1'b0 || ur_a !== 1'b0) begin
            fails++; $display("FAIL async_reset: pixel %0d valid %b req %b underrun %b want all 0", bus_a.pixel, bus_a.pixel_valid, bus_a.word_req, ur_a);
        end
        bus_a.word_ack = 1'b0; en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_bpp8_sparse_enable();
        test_underrun();
        test_wrap_ack();
        test_restart_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
